// File: rtl/md_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_ctrl_pkg : shared encodings and widths for the MD element access controller
// Rev 1.0
// ----------------------------------------------------------------------------
package md_ctrl_pkg;

   localparam int DIN_W_DEF     = 210;
   localparam int DOUT_W_DEF    = 192;
   localparam int WORD_W        = 32;
   localparam int TAIL_WORD     = 6;
   localparam int TAIL_BITS     = 18;
   localparam int NUM_OUT_WORDS = 6;
   localparam int TMR_W         = 8;

   typedef enum logic [1:0] {
      OP_WRITE_ELEM = 2'd0,
      OP_READ_ELEM  = 2'd1,
      OP_SOFT_RESET = 2'd2,
      OP_CLR_ERR    = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WPULSE = 3'd1,
      ST_RREQ   = 3'd2,
      ST_RWAIT  = 3'd3,
      ST_RHOLD  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/md_shadow_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_shadow_buf : holds the last captured element read, exposed one word at a time
// Rev 1.0
// ----------------------------------------------------------------------------
module md_shadow_buf
   import md_ctrl_pkg::*;
#(
   parameter int DOUT_W = DOUT_W_DEF
)(
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              cap_en,
   input  logic [DOUT_W-1:0] cap_data,
   input  logic [2:0]        rd_addr,
   output logic [31:0]       rd_data
);

   localparam int NUM_WORDS = DOUT_W / WORD_W;

   logic [DOUT_W-1:0] shadow_q;
   logic [DOUT_W-1:0] shadow_d;
   logic [WORD_W-1:0] word_w [8];

   always_comb begin
      shadow_d = cap_en ? cap_data : shadow_q;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   // Indices past the last captured word read back as zero.
   for (genvar gi = 0; gi < 8; gi++) begin : g_word
      if (gi < NUM_WORDS) begin : g_live
         assign word_w[gi] = shadow_q[gi*WORD_W +: WORD_W];
      end else begin : g_zero
         assign word_w[gi] = '0;
      end
   end

   assign rd_data = word_w[rd_addr];

endmodule
`default_nettype wire

// File: rtl/md_elem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_elem_access_ctrl : sequences host register access to the MD element port
// Rev 1.0
// ----------------------------------------------------------------------------
module md_elem_access_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int DIN_W      = DIN_W_DEF,
   parameter int DOUT_W     = DOUT_W_DEF,
   parameter int RD_LATENCY = 2,
   parameter int RST_CYCLES = 16,
   parameter int CNT_W      = 16
)(
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [31:0]       wr_data,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   output logic              cmd_ready,
   input  logic [2:0]        rd_addr,
   output logic [31:0]       rd_data,
   output logic              busy,
   output logic              err,
   output logic [CNT_W-1:0]  wr_count,
   output logic [DIN_W-1:0]  md_d_in,
   output logic              md_elem_write,
   output logic              md_elem_read,
   output logic              md_read_ctrl,
   input  logic [DOUT_W-1:0] md_d_out,
   output logic              md_reset_n
);

   state_e             state_q, state_d;
   logic [DIN_W-1:0]   md_d_in_q, md_d_in_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               err_q, err_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               md_elem_write_q, md_elem_write_d;
   logic               md_elem_read_q, md_elem_read_d;
   logic               md_read_ctrl_q, md_read_ctrl_d;
   logic               md_reset_n_q, md_reset_n_d;
   logic               capture_w;

   always_comb begin
      state_d         = state_q;
      md_d_in_d       = md_d_in_q;
      wr_count_d      = wr_count_q;
      tmr_d           = tmr_q;
      err_d           = err_q;
      md_elem_write_d = 1'b0;
      md_elem_read_d  = 1'b0;
      md_read_ctrl_d  = md_read_ctrl_q;
      md_reset_n_d    = md_reset_n_q;
      capture_w       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  OP_WRITE_ELEM: begin
                     state_d         = ST_WPULSE;
                     md_elem_write_d = 1'b1;
                  end
                  OP_READ_ELEM: begin
                     state_d        = ST_RREQ;
                     md_elem_read_d = 1'b1;
                     md_read_ctrl_d = 1'b1;
                  end
                  OP_SOFT_RESET: begin
                     state_d      = ST_RHOLD;
                     md_reset_n_d = 1'b0;
                     wr_count_d   = '0;
                     tmr_d        = TMR_W'(RST_CYCLES - 1);
                  end
                  default: err_d = 1'b0;
               endcase
            end
         end
         ST_WPULSE: begin
            wr_count_d = wr_count_q + CNT_W'(1);
            state_d    = ST_IDLE;
         end
         ST_RREQ: begin
            tmr_d   = TMR_W'(RD_LATENCY - 1);
            state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (tmr_q == '0) begin
               capture_w      = 1'b1;
               md_read_ctrl_d = 1'b0;
               state_d        = ST_IDLE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_RHOLD: begin
            if (tmr_q == '0) begin
               md_reset_n_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Evaluated after the command so a bad write in a CLR_ERR cycle still sticks,
      // and a legal write lands in the same edge that raises the write pulse.
      if (wr_en) begin
         if (state_q != ST_IDLE || wr_addr == 3'd7) begin
            err_d = 1'b1;
         end else begin
            for (int k = 0; k < TAIL_WORD; k++) begin
               if (wr_addr == 3'(k)) begin
                  md_d_in_d[k*WORD_W +: WORD_W] = wr_data;
               end
            end
            if (wr_addr == 3'(TAIL_WORD)) begin
               md_d_in_d[TAIL_WORD*WORD_W +: TAIL_BITS] = wr_data[TAIL_BITS-1:0];
            end
         end
      end

      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q         <= ST_IDLE;
         md_d_in_q       <= '0;
         wr_count_q      <= '0;
         tmr_q           <= '0;
         err_q           <= 1'b0;
         cmd_ready_q     <= 1'b1;
         md_elem_write_q <= 1'b0;
         md_elem_read_q  <= 1'b0;
         md_read_ctrl_q  <= 1'b0;
         md_reset_n_q    <= 1'b1;
      end else begin
         state_q         <= state_d;
         md_d_in_q       <= md_d_in_d;
         wr_count_q      <= wr_count_d;
         tmr_q           <= tmr_d;
         err_q           <= err_d;
         cmd_ready_q     <= cmd_ready_d;
         md_elem_write_q <= md_elem_write_d;
         md_elem_read_q  <= md_elem_read_d;
         md_read_ctrl_q  <= md_read_ctrl_d;
         md_reset_n_q    <= md_reset_n_d;
      end
   end

   md_shadow_buf #(
      .DOUT_W (DOUT_W)
   ) u_shadow (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .cap_en   (capture_w),
      .cap_data (md_d_out),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   assign cmd_ready     = cmd_ready_q;
   assign busy          = ~cmd_ready_q;
   assign err           = err_q;
   assign wr_count      = wr_count_q;
   assign md_d_in       = md_d_in_q;
   assign md_elem_write = md_elem_write_q;
   assign md_elem_read  = md_elem_read_q;
   assign md_read_ctrl  = md_read_ctrl_q;
   assign md_reset_n    = md_reset_n_q;

endmodule
`default_nettype wire

// File: tb/tb_md_elem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_md_elem_access_ctrl : scoreboard bench for md_elem_access_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_md_elem_access_ctrl;

   localparam int TB_RD_LAT  = 2;
   localparam int TB_RST_CYC = 16;
   localparam int TB_CNT_W   = 8;

   localparam int P_DIN   = 0;
   localparam int P_WRCNT = 1;
   localparam int P_ERR   = 2;
   localparam int P_READY = 3;
   localparam int P_BUSY  = 4;
   localparam int P_RSTN  = 5;
   localparam int P_EW    = 6;
   localparam int P_ER    = 7;
   localparam int P_RC    = 8;
   localparam int P_RD    = 9;

   logic                ap_clk = 1'b0;
   logic                ap_rst = 1'b1;
   logic                wr_en = 1'b0;
   logic [2:0]          wr_addr = '0;
   logic [31:0]         wr_data = '0;
   logic                cmd_valid = 1'b0;
   logic [1:0]          cmd_op = '0;
   logic                cmd_ready;
   logic [2:0]          rd_addr = '0;
   logic [31:0]         rd_data;
   logic                busy;
   logic                err;
   logic [TB_CNT_W-1:0] wr_count;
   logic [209:0]        md_d_in;
   logic                md_elem_write;
   logic                md_elem_read;
   logic                md_read_ctrl;
   logic [191:0]        md_d_out = '0;
   logic                md_reset_n;

   md_elem_access_ctrl #(
      .DIN_W      (210),
      .DOUT_W     (192),
      .RD_LATENCY (TB_RD_LAT),
      .RST_CYCLES (TB_RST_CYC),
      .CNT_W      (TB_CNT_W)
   ) dut (
      .ap_clk        (ap_clk),
      .ap_rst        (ap_rst),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .cmd_valid     (cmd_valid),
      .cmd_op        (cmd_op),
      .cmd_ready     (cmd_ready),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .busy          (busy),
      .err           (err),
      .wr_count      (wr_count),
      .md_d_in       (md_d_in),
      .md_elem_write (md_elem_write),
      .md_elem_read  (md_elem_read),
      .md_read_ctrl  (md_read_ctrl),
      .md_d_out      (md_d_out),
      .md_reset_n    (md_reset_n)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int           kind;
      logic [209:0] exp;
      string        name;
   } probe_t;

   probe_t       q_probe[$];
   logic [209:0] q_wr[$];
   int           q_rc[$];
   int           q_rstw[$];

   int n_cmp = 0;
   int n_err = 0;
   int rc_len = 0;
   int rn_len = 0;
   logic [209:0] exp_din = '0;
   logic [191:0] rd_pat = {6{32'hA5A5A5A5}};

   task automatic chk(input string name, input logic [209:0] act, input logic [209:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: DUT event seen, expected none", name);
   endtask

   task automatic probe(input int kind, input logic [209:0] exp, input string name);
      probe_t p;
      p.kind = kind;
      p.exp  = exp;
      p.name = name;
      q_probe.push_back(p);
   endtask

   function automatic logic [209:0] stage_model(input logic [209:0] din, input logic [2:0] a,
                                                input logic [31:0] d);
      logic [209:0] r;
      r = din;
      if (a <= 3'd5) r[a*32 +: 32] = d;
      else if (a == 3'd6) r[209:192] = d[17:0];
      return r;
   endfunction

   task automatic issue_cmd(input logic [1:0] op);
      int guard;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 64) begin
         @(posedge ap_clk); #1;
         guard++;
      end
      if (guard == 64) begin
         n_cmp++;
         n_err++;
         $display("FAIL cmd_ready_timeout: got %b, expected 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge ap_clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic stage(input logic [2:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      exp_din = stage_model(exp_din, a, d);
      @(posedge ap_clk); #1;
      wr_en = 1'b0;
   endtask

   // Monitor: pulse/width events pop their own queues; probes are drained every cycle.
   always @(negedge ap_clk) begin
      if (md_elem_write === 1'b1 || md_elem_read === 1'b1)
         chk("pulse_exclusive", 210'(md_elem_write & md_elem_read), '0);
      if (md_elem_write === 1'b1) begin
         if (q_wr.size() == 0) unexpected("md_elem_write");
         else chk("pulse_d_in", md_d_in, q_wr.pop_front());
      end
      if (md_read_ctrl === 1'b1) rc_len++;
      else if (rc_len != 0) begin
         if (q_rc.size() == 0) unexpected("md_read_ctrl");
         else chk("read_ctrl_len", 210'(rc_len), 210'(q_rc.pop_front()));
         rc_len = 0;
      end
      if (md_reset_n === 1'b0) rn_len++;
      else if (rn_len != 0) begin
         if (q_rstw.size() == 0) unexpected("md_reset_n");
         else chk("reset_n_len", 210'(rn_len), 210'(q_rstw.pop_front()));
         rn_len = 0;
      end
      while (q_probe.size() != 0) begin
         probe_t p;
         logic [209:0] act;
         p = q_probe.pop_front();
         case (p.kind)
            P_DIN:   act = md_d_in;
            P_WRCNT: act = 210'(wr_count);
            P_ERR:   act = 210'(err);
            P_READY: act = 210'(cmd_ready);
            P_BUSY:  act = 210'(busy);
            P_RSTN:  act = 210'(md_reset_n);
            P_EW:    act = 210'(md_elem_write);
            P_ER:    act = 210'(md_elem_read);
            P_RC:    act = 210'(md_read_ctrl);
            default: act = 210'(rd_data);
         endcase
         chk(p.name, act, p.exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge ap_clk);
      #1 ap_rst = 1'b0;

      // Reset state
      probe(P_DIN, '0, "rst_d_in");
      probe(P_WRCNT, '0, "rst_wr_count");
      probe(P_ERR, '0, "rst_err");
      probe(P_READY, 1, "rst_ready");
      probe(P_BUSY, '0, "rst_busy");
      probe(P_RSTN, 1, "rst_reset_n");
      probe(P_EW, '0, "rst_elem_write");
      probe(P_ER, '0, "rst_elem_read");
      probe(P_RC, '0, "rst_read_ctrl");
      probe(P_RD, '0, "rst_rd_data");
      @(posedge ap_clk); #1;

      // Stage all seven words, then write the element
      for (int k = 0; k < 6; k++) stage(3'(k), 32'h11111111 * (k + 1));
      stage(3'd6, 32'hFFFFFFFF);
      probe(P_DIN, {18'h3FFFF, 32'h66666666, 32'h55555555, 32'h44444444,
                    32'h33333333, 32'h22222222, 32'h11111111}, "staged_d_in");
      q_wr.push_back(exp_din);
      issue_cmd(2'd0);
      probe(P_EW, 1, "write_pulse_hi");
      probe(P_BUSY, 1, "write_busy");
      probe(P_READY, '0, "write_not_ready");
      @(posedge ap_clk); #1;
      probe(P_EW, '0, "write_pulse_lo");
      probe(P_WRCNT, 1, "wr_count_1");
      probe(P_READY, 1, "write_done_ready");

      // Timed read with a staging write attempted during the wait
      q_rc.push_back(TB_RD_LAT + 1);
      issue_cmd(2'd1);
      probe(P_ER, 1, "read_pulse_hi");
      probe(P_RC, 1, "read_ctrl_req");
      rd_addr = 3'd0;
      for (int c = 1; c <= TB_RD_LAT; c++) begin
         @(posedge ap_clk); #1;
         wr_en    = (c == 1);
         wr_addr  = 3'd0;
         wr_data  = 32'hDEADBEEF;
         md_d_out = (c == TB_RD_LAT) ? rd_pat : '0;
         probe(P_RD, '0, "rd_old_shadow");
         probe(P_ER, '0, "read_pulse_lo");
         if (c == TB_RD_LAT) probe(P_ERR, 1, "err_wr_in_rwait");
      end
      @(posedge ap_clk); #1;
      wr_en    = 1'b0;
      md_d_out = '0;
      probe(P_READY, 1, "read_done_ready");
      probe(P_DIN, exp_din, "d_in_kept_rwait");
      probe(P_RD, 32'hA5A5A5A5, "rd_word0");
      for (int a = 1; a < 8; a++) begin
         @(posedge ap_clk); #1;
         rd_addr = 3'(a);
         probe(P_RD, (a < 6) ? 210'h0A5A5A5A5 : '0, "rd_word_n");
      end

      // Error clear, illegal address, clear again
      issue_cmd(2'd3);
      probe(P_ERR, '0, "err_cleared");
      probe(P_READY, 1, "clr_ready");
      stage(3'd7, 32'hFFFFFFFF);
      probe(P_ERR, 1, "err_addr7");
      probe(P_DIN, exp_din, "d_in_kept_addr7");
      issue_cmd(2'd3);
      probe(P_ERR, '0, "err_cleared2");

      // Staging write in the same cycle as WRITE_ELEM
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = 32'hCAFEF00D;
      exp_din = stage_model(exp_din, 3'd0, 32'hCAFEF00D);
      q_wr.push_back(exp_din);
      issue_cmd(2'd0);
      wr_en = 1'b0;
      probe(P_EW, 1, "simul_pulse");
      @(posedge ap_clk); #1;
      probe(P_WRCNT, 2, "wr_count_2");

      // Full soft reset
      rd_addr = 3'd0;
      q_rstw.push_back(TB_RST_CYC);
      issue_cmd(2'd2);
      probe(P_WRCNT, '0, "wr_count_cleared");
      for (int i = 0; i < TB_RST_CYC; i++) begin
         probe(P_RSTN, '0, "rhold_reset_n");
         probe(P_READY, '0, "rhold_ready");
         @(posedge ap_clk); #1;
      end
      probe(P_RSTN, 1, "rhold_end_reset_n");
      probe(P_READY, 1, "rhold_end_ready");
      probe(P_DIN, exp_din, "rhold_d_in_kept");
      probe(P_RD, 32'hA5A5A5A5, "rhold_shadow_kept");
      @(posedge ap_clk); #1;

      // Soft reset aborted by ap_rst in its fifth cycle
      q_rstw.push_back(5);
      issue_cmd(2'd2);
      repeat (4) begin @(posedge ap_clk); #1; end
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst  = 1'b0;
      exp_din = '0;
      probe(P_RSTN, 1, "abort_reset_n");
      probe(P_READY, 1, "abort_ready");
      probe(P_BUSY, '0, "abort_busy");
      probe(P_DIN, '0, "abort_d_in");
      probe(P_RD, '0, "abort_shadow");
      @(posedge ap_clk); #1;

      // Counter wrap
      for (int i = 0; i < (1 << TB_CNT_W); i++) begin
         q_wr.push_back(exp_din);
         issue_cmd(2'd0);
         @(posedge ap_clk); #1;
         if (i == (1 << TB_CNT_W) - 2) probe(P_WRCNT, (1 << TB_CNT_W) - 1, "wr_count_max");
      end
      probe(P_WRCNT, '0, "wr_count_wrap");
      probe(P_ERR, '0, "err_end");

      repeat (3) @(posedge ap_clk);
      #1;
      chk("q_wr_drained", 210'(q_wr.size()), '0);
      chk("q_rc_drained", 210'(q_rc.size()), '0);
      chk("q_rstw_drained", 210'(q_rstw.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/md_elem_access_ctrl.md
Name: md_elem_access_ctrl

Overview:
- Sequences host (AXI-Lite register) access to the MD wrapper's element port.
- Assembles the 210-bit element input from 32-bit register writes, then issues single-cycle element write pulses.
- Runs timed element reads and captures the 192-bit result into a shadow buffer the register file reads word by word.
- Generates the timed debug soft-reset; sits between the axi4lite register block and MD_Wrapper inside MD_RL.

Parameters:
- DIN_W, 210, element input width (6 full words + 18-bit tail word)
- DOUT_W, 192, element output width (6 words)
- RD_LATENCY, 2, cycles from md_elem_read pulse to valid md_d_out (1..15)
- RST_CYCLES, 16, cycles md_reset_n is held low for soft reset (2..255)
- CNT_W, 16, width of the completed-write counter

Ports:
- ap_clk  in  1  sole clock
- ap_rst  in  1  synchronous active-high reset
- wr_en  in  1  staging word write strobe
- wr_addr  in  3  staging word index 0..6
- wr_data  in  32  staging word data
- cmd_valid  in  1  command request
- cmd_op  in  2  0=WRITE_ELEM 1=READ_ELEM 2=SOFT_RESET 3=CLR_ERR
- cmd_ready  out  1  high only in IDLE
- rd_addr  in  3  shadow word index 0..5
- rd_data  out  32  combinational shadow word select
- busy  out  1  FSM not in IDLE
- err  out  1  sticky protocol error
- wr_count  out  CNT_W  completed element writes
- md_d_in  out  DIN_W  staged element, registered
- md_elem_write  out  1  one-cycle write pulse
- md_elem_read  out  1  one-cycle read pulse
- md_read_ctrl  out  1  high from the read pulse through capture
- md_d_out  in  DOUT_W  element read data
- md_reset_n  out  1  active-low MD datapath reset

Behaviour:
- Reset values:
  - md_d_in=0, shadow=0, wr_count=0, err=0.
  - md_elem_write=0, md_elem_read=0, md_read_ctrl=0, md_reset_n=1.
  - State=IDLE, cmd_ready=1, busy=0.
- Staging writes:
  - wr_en in IDLE writes word wr_addr of md_d_in: word k is bits [32k+31:32k]; word 6 keeps only wr_data[17:0] into bits [209:192].
  - wr_en with wr_addr=7 is dropped and sets err.
  - wr_en outside IDLE is dropped and sets err; md_d_in stays stable.
- Commands are accepted only when cmd_valid && cmd_ready.
- States and transitions:
  - IDLE: WRITE_ELEM -> WPULSE; READ_ELEM -> RREQ; SOFT_RESET -> RHOLD; CLR_ERR clears err and stays in IDLE.
  - WPULSE (1 cycle): md_elem_write=1; wr_count++ (wraps at 2^CNT_W-1 -> 0); next state IDLE.
  - RREQ (1 cycle): md_elem_read=1, md_read_ctrl=1; load latency counter with RD_LATENCY-1; next state RWAIT.
  - RWAIT: md_read_ctrl=1; counter decrements; at 0, capture md_d_out into shadow on that edge, then go to IDLE.
  - Read timing: capture occurs exactly RD_LATENCY cycles after the md_elem_read cycle.
  - RHOLD: md_reset_n=0 for exactly RST_CYCLES cycles. wr_count is cleared on entry; md_d_in and shadow are preserved. Next state IDLE.
- Simultaneous wr_en and accepted WRITE_ELEM in the same IDLE cycle: the word update lands first, so the pulse carries the new word.
- rd_data:
  - rd_data = shadow word rd_addr; rd_addr 6 or 7 returns 0.
  - Reads during RWAIT return the old shadow until the capture edge.
- ap_rst mid-operation: immediate return to IDLE with all reset values. This includes md_reset_n=1, so an in-progress soft reset is aborted.
- Pulse rule: every pulse output is registered, and no two pulses occur in the same cycle.

Decomposition:
- Package md_ctrl_pkg holds:
  - cmd_op encodings;
  - FSM state encoding (IDLE, WPULSE, RREQ, RWAIT, RHOLD);
  - DIN_W/DOUT_W defaults;
  - word-index constants (TAIL_WORD=6, TAIL_BITS=18).
- One natural sub-module, md_shadow_buf: the 6x32 capture register with its rd_addr read mux.
- The FSM, staging register and counters stay in the top.

Test Plan:
- Write staging words 0..6 = 0x11111111*(k+1) (word 6 = 0x3FFFF), then WRITE_ELEM -> single md_elem_write pulse one cycle after acceptance; md_d_in[209:192]=0x3FFFF; wr_count=1.
- READ_ELEM with md_d_out driven to 0xA5A5..A5 only in the RD_LATENCY-th cycle after md_elem_read (other cycles 0) -> rd_data for addr 0..5 = 0xA5A5A5A5; md_read_ctrl high exactly RD_LATENCY+1 cycles.
- SOFT_RESET -> md_reset_n low exactly 16 cycles, cmd_ready low throughout, wr_count=0, staging preserved.
- wr_en during RWAIT, and wr_en with wr_addr=7 in IDLE -> each write dropped, err=1; CLR_ERR -> err=0.
- Assert ap_rst on cycle 5 of RHOLD -> next cycle md_reset_n=1, state IDLE, md_d_in=0.
- 65536 WRITE_ELEM commands with CNT_W=16 -> wr_count wraps to 0.
